rca32: RTL and testbench
========================

RCA32 -- requirements
Module: rca32

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s  output  32  registered sum bits [31:0].
REQ-005 cout  output  1  registered carry-out of bit 31.
REQ-006 a  input  32  addend A, unsigned.
REQ-007 b  input  32  addend B, unsigned.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 Port order SHALL be clk, rst, s, cout, a, b, cin.

Function
REQ-010 The adder core SHALL be a true ripple-carry structure of 32 one-bit full adders, with bit i's carry-out feeding bit i+1's carry-in.
REQ-011 Each full adder SHALL compute sum = x XOR y XOR c and carry = (x AND y) OR (c AND (x XOR y)).
REQ-012 The core SHALL be built hierarchically: full adder, then 4-bit ripple slice, then eight chained slices forming 32 bits.
REQ-013 The core SHALL use no carry-lookahead, carry-select or tool arithmetic operators ("+") in the datapath.
REQ-014 {cout, s} SHALL equal a + b + cin, evaluated as 33-bit unsigned arithmetic.
REQ-015 On each rising clk edge with rst low, s and cout SHALL capture the core result from a, b and cin sampled at that edge; latency is 1 cycle.
REQ-016 s and cout SHALL hold their values between edges regardless of input changes.
REQ-017 Wrap-around: when a + b + cin >= 2^32, s SHALL be the low 32 bits and cout SHALL be 1.
REQ-018 The module SHALL raise no overflow or error flag; signed interpretation is left to the user (signed overflow = carry into bit 31 XOR cout, not exported).
REQ-019 Inputs containing X or Z SHALL NOT be specially handled; behavior follows gate semantics.
REQ-020 The module SHALL contain no handshake; a new operation is accepted on every cycle.

Reset
REQ-021 While rst is high, s SHALL be 32'h0000_0000 and cout SHALL be 0, asynchronously and independent of clk.
REQ-022 On rst deassertion, the first rising clk edge with rst low SHALL load the current core result.
REQ-023 If rst asserts mid-stream, the pending result SHALL be discarded; no result SHALL be recovered after reset.
REQ-024 Reset SHALL affect only the output registers; the core remains combinational.

Verification
REQ-025 rst=1, then a=0, b=0, cin=0, with clocks running -> s=0, cout=0 throughout reset and after the first edge with rst low.
REQ-026 Exhaustive sweep of a in 0..5 and b in 0..5, with cin=0, one pair per cycle -> each result appears one edge later with s=a+b and cout=0 (for example, 5+5 gives s=10).
REQ-027 a=32'hFFFF_FFFF, b=1, cin=0 -> s=0, cout=1; then a=32'hFFFF_FFFF, b=0, cin=1 -> s=0, cout=1 (full carry ripple through 32 bits).
REQ-028 a=32'h7FFF_FFFF, b=1, cin=0 -> s=32'h8000_0000, cout=0; then a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, cin=1 -> s=32'hFFFF_FFFF, cout=1.
REQ-029 Start a=3, b=4; assert rst asynchronously between edges -> s=0 and cout=0 immediately without a clock edge; after deassertion, next edge gives s=7.
REQ-030 Random test of at least 10,000 (a, b, cin) vectors -> {cout, s} SHALL match the 33-bit reference sum one cycle later.

Source files
------------

// File: rtl/rca32.sv
// Registered 32-bit ripple-carry adder: full adder -> 4-bit slice -> 8 slices; 1-cycle latency.
// No backpressure: a new (a, b, cin) is accepted on every clock.

module rca32_fa (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic sum,
  output logic carry
);
  logic p;

  assign p     = x ^ y;
  assign sum   = p ^ c;
  assign carry = (x & y) | (c & p);
endmodule

module rca32_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c,
  output logic [3:0] sum,
  output logic       carry
);
  logic [4:0] cy;

  assign cy[0] = c;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    rca32_fa u_fa (
      .x     (x[i]),
      .y     (y[i]),
      .c     (cy[i]),
      .sum   (sum[i]),
      .carry (cy[i+1])
    );
  end

  assign carry = cy[4];
endmodule

module rca32 (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] s,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin
);
  logic [8:0]  cy;
  logic [31:0] sum;

  assign cy[0] = cin;

  // Slice k's carry-out ripples straight into slice k+1; no lookahead anywhere.
  for (genvar k = 0; k < 8; k++) begin : g_slice
    rca32_slice4 u_slice (
      .x     (a[4*k +: 4]),
      .y     (b[4*k +: 4]),
      .c     (cy[k]),
      .sum   (sum[4*k +: 4]),
      .carry (cy[k+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= 32'h0000_0000;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= cy[8];
    end
  end
endmodule

// File: tb/tb_rca32.sv
// Directed and random checks of rca32 against hand values and a 33-bit reference sum.
module tb_rca32;
  logic        clk;
  logic        rst;
  logic [31:0] s;
  logic        cout;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;

  int checks;
  int passed;

  rca32 dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s),
    .cout (cout),
    .a    (a),
    .b    (b),
    .cin  (cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; results are sampled 1 time unit after the rising edge.
  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic vc);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
  endtask

  task automatic capture();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] ref_sum;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    checks = 0;
    passed = 0;
    rst = 1'b1;
    a   = 32'd0;
    b   = 32'd0;
    cin = 1'b0;

    // Reset held across running clocks.
    #1;
    check("reset_initial", {cout, s}, 33'h0);
    capture();
    check("reset_edge1", {cout, s}, 33'h0);
    capture();
    check("reset_edge2", {cout, s}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    capture();
    check("first_edge_after_reset", {cout, s}, 33'h0);

    // Small exhaustive sweep, one pair per cycle.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        apply(i, j, 1'b0);
        capture();
        check($sformatf("sweep_%0d_plus_%0d", i, j), {cout, s}, i + j);
      end
    end

    // Output holds between edges while inputs move.
    apply(32'd5, 32'd5, 1'b0);
    capture();
    check("hold_before", {cout, s}, 33'd10);
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    cin = 1'b1;
    #2;
    check("hold_after_input_change", {cout, s}, 33'd10);

    // Full-length carry ripples and boundaries.
    apply(32'hFFFF_FFFF, 32'd1, 1'b0);
    capture();
    check("ffffffff_plus_1", {cout, s}, {1'b1, 32'h0000_0000});
    apply(32'hFFFF_FFFF, 32'd0, 1'b1);
    capture();
    check("ffffffff_plus_cin", {cout, s}, {1'b1, 32'h0000_0000});
    apply(32'h7FFF_FFFF, 32'd1, 1'b0);
    capture();
    check("7fffffff_plus_1", {cout, s}, {1'b0, 32'h8000_0000});
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    capture();
    check("max_plus_max_plus_cin", {cout, s}, {1'b1, 32'hFFFF_FFFF});
    apply(32'h0000_0000, 32'h0000_0000, 1'b1);
    capture();
    check("cin_only", {cout, s}, 33'd1);

    // Asynchronous reset mid-cycle clears the nonzero result without an edge.
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    capture();
    check("pre_async_reset", {cout, s}, {1'b1, 32'hFFFF_FFFF});
    apply(32'd3, 32'd4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", {cout, s}, 33'h0);
    capture();
    check("async_reset_held_over_edge", {cout, s}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_released_no_edge", {cout, s}, 33'h0);
    capture();
    check("after_reset_3_plus_4", {cout, s}, 33'd7);

    // Random vectors against the 33-bit reference.
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      apply(ra, rb, rc);
      capture();
      check("random", {cout, s}, ref_sum);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
